// File: rtl/cpu_isa_pkg.sv
// ISA constants, fetch FSM state encoding and the 2-byte opcode predicate.
`timescale 1ns/1ps
package cpu_isa_pkg;

    localparam logic [3:0] OPC_LOAD  = 4'b1001;
    localparam logic [3:0] OPC_STORE = 4'b1101;
    localparam logic [3:0] OPC_ADD   = 4'b0001;
    localparam logic [7:0] INSTR_HLT = 8'hFF;

    // ST_STEP_WAIT is only reachable when single-step gating is compiled in.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH_OP,
        ST_FETCH_IMM,
        ST_ISSUE,
        ST_HALT,
        ST_STEP_WAIT
    } fetch_state_t;

    function automatic logic is_two_byte(input logic [3:0] opcode);
        return (opcode == OPC_LOAD) || (opcode == OPC_STORE);
    endfunction

endpackage

// File: rtl/instr_field_split.sv
// Instruction byte decoder: splits a byte into opcode/rd/rs and flags HLT and 2-byte forms.
// Latency: combinational. Backpressure: none.
`timescale 1ns/1ps
module instr_field_split
    import cpu_isa_pkg::*;
(
    input  logic [7:0] instr,
    output logic [3:0] opcode,
    output logic [1:0] rd,
    output logic [1:0] rs,
    output logic       is_hlt,
    output logic       two_byte
);

    assign opcode   = instr[7:4];
    assign rd       = instr[3:2];
    assign rs       = instr[1:0];
    assign is_hlt   = (instr == INSTR_HLT);
    // HLT's opcode nibble is not a 2-byte form, but gate it anyway so HLT always wins.
    assign two_byte = !is_hlt && is_two_byte(instr[7:4]);

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch/issue sequencer: owns the PC, assembles 1/2-byte instructions, stops on HLT; FETCH_SINGLE_STEP_EN adds a step gate.
// Latency: issue_valid 2 cycles after run for a 1-byte instruction, 3 for a 2-byte one.
// Backpressure: issue fields held while issue_valid && !issue_ready; a redirect drops the pending issue.
`timescale 1ns/1ps
module fetch_sequencer
    import cpu_isa_pkg::*;
#(
    parameter int                ADDR_W   = 8,
    parameter int                DATA_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
`ifdef FETCH_SINGLE_STEP_EN
    input  logic              step,
`endif
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_data,
    output logic              issue_valid,
    input  logic              issue_ready,
    output logic [3:0]        issue_opcode,
    output logic [1:0]        issue_rd,
    output logic [1:0]        issue_rs,
    output logic [DATA_W-1:0] issue_imm,
    input  logic              redir_valid,
    input  logic [ADDR_W-1:0] redir_addr,
    output logic              halted,
    output logic [ADDR_W-1:0] pc
);

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [3:0]        op_q, op_d;
    logic [1:0]        rd_q, rd_d;
    logic [1:0]        rs_q, rs_d;
    logic [DATA_W-1:0] imm_q, imm_d;
    logic              halted_q, halted_d;
    logic              step_ok;

    logic [3:0]        dec_opcode;
    logic [1:0]        dec_rd;
    logic [1:0]        dec_rs;
    logic              dec_hlt;
    logic              dec_two;

`ifdef FETCH_SINGLE_STEP_EN
    assign step_ok = step;
`else
    assign step_ok = 1'b1;
`endif

    instr_field_split u_split (
        .instr    (imem_data[7:0]),
        .opcode   (dec_opcode),
        .rd       (dec_rd),
        .rs       (dec_rs),
        .is_hlt   (dec_hlt),
        .two_byte (dec_two)
    );

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        op_d     = op_q;
        rd_d     = rd_q;
        rs_d     = rs_q;
        imm_d    = imm_q;
        halted_d = halted_q;

        case (state_q)
            ST_IDLE: begin
                if (run) begin
                    state_d = step_ok ? ST_FETCH_OP : ST_STEP_WAIT;
                end
            end
            ST_STEP_WAIT: begin
                if (redir_valid) begin
                    pc_d = redir_addr;
                end
                if (step_ok) begin
                    state_d = ST_FETCH_OP;
                end
            end
            ST_FETCH_OP: begin
                if (redir_valid) begin
                    pc_d    = redir_addr;
                    state_d = ST_FETCH_OP;
                end else begin
                    op_d = dec_opcode;
                    rd_d = dec_rd;
                    rs_d = dec_rs;
                    pc_d = pc_q + ADDR_W'(1);
                    if (dec_hlt) begin
                        halted_d = 1'b1;
                        state_d  = ST_HALT;
                    end else if (dec_two) begin
                        state_d = ST_FETCH_IMM;
                    end else begin
                        imm_d   = '0;
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_FETCH_IMM: begin
                if (redir_valid) begin
                    pc_d    = redir_addr;
                    state_d = ST_FETCH_OP;
                end else begin
                    imm_d   = imem_data;
                    pc_d    = pc_q + ADDR_W'(1);
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // A redirect coinciding with accept still counts the accept; the redirect wins the PC.
                if (redir_valid) begin
                    pc_d    = redir_addr;
                    state_d = ST_FETCH_OP;
                end else if (issue_ready) begin
                    state_d = step_ok ? ST_FETCH_OP : ST_STEP_WAIT;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            pc_q     <= RESET_PC;
            op_q     <= '0;
            rd_q     <= '0;
            rs_q     <= '0;
            imm_q    <= '0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            op_q     <= op_d;
            rd_q     <= rd_d;
            rs_q     <= rs_d;
            imm_q    <= imm_d;
            halted_q <= halted_d;
        end
    end

    assign issue_valid  = (state_q == ST_ISSUE);
    assign issue_opcode = op_q;
    assign issue_rd     = rd_q;
    assign issue_rs     = rs_q;
    assign issue_imm    = imm_q;
    assign imem_addr    = pc_q;
    assign pc           = pc_q;
    assign halted       = halted_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: an instruction-level walk of the memory image predicts the issue stream.
`timescale 1ns/1ps
module tb_fetch_sequencer;

    typedef struct packed {
        logic [3:0] op;
        logic [1:0] rd;
        logic [1:0] rs;
        logic [7:0] imm;
    } iss_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       run;
    logic       issue_ready;
    logic       redir_valid;
    logic [7:0] redir_addr;
`ifdef FETCH_SINGLE_STEP_EN
    logic       step;
`endif
    logic [7:0] imem_addr;
    logic [7:0] imem_data;
    logic       issue_valid;
    logic [3:0] issue_opcode;
    logic [1:0] issue_rd;
    logic [1:0] issue_rs;
    logic [7:0] issue_imm;
    logic       halted;
    logic [7:0] pc;

    logic [7:0] mem [256];
    iss_t       exp_q[$];
    int         tests = 0;
    int         fails = 0;
    int         n_issued = 0;
    bit         rand_mode = 0;
    logic       ready_force = 1'b1;

    assign imem_data = mem[imem_addr];

    always #5 clk = ~clk;

    fetch_sequencer #(.ADDR_W(8), .DATA_W(8), .RESET_PC(8'h00)) dut (
        .clk          (clk),
        .rst          (rst),
        .run          (run),
`ifdef FETCH_SINGLE_STEP_EN
        .step         (step),
`endif
        .imem_addr    (imem_addr),
        .imem_data    (imem_data),
        .issue_valid  (issue_valid),
        .issue_ready  (issue_ready),
        .issue_opcode (issue_opcode),
        .issue_rd     (issue_rd),
        .issue_rs     (issue_rs),
        .issue_imm    (issue_imm),
        .redir_valid  (redir_valid),
        .redir_addr   (redir_addr),
        .halted       (halted),
        .pc           (pc)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Advance one cycle; inputs change 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        issue_ready = rand_mode ? ($urandom_range(0, 9) < 7) : ready_force;
    endtask

    // Reference: interpret the memory one instruction at a time from start until HLT.
    task automatic model_walk(input logic [7:0] start, input int max_n, output logic [7:0] halt_pc);
        logic [7:0] p;
        logic [7:0] b;
        iss_t       e;
        int         n;
        p = start;
        n = 0;
        halt_pc = 8'h00;
        for (int i = 0; i < 600; i++) begin
            b = mem[p];
            p = p + 8'd1;
            if (b == 8'hFF) begin
                halt_pc = p;
                break;
            end
            e.op = b[7:4];
            e.rd = b[3:2];
            e.rs = b[1:0];
            e.imm = 8'h00;
            if (b[7:4] == 4'h9 || b[7:4] == 4'hD) begin
                e.imm = mem[p];
                p = p + 8'd1;
            end
            if (n < max_n) exp_q.push_back(e);
            n++;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        run = 1'b0;
        redir_valid = 1'b0;
        redir_addr = 8'h00;
`ifdef FETCH_SINGLE_STEP_EN
        step = 1'b1;
`endif
        exp_q.delete();
        repeat (2) tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic load_prog1();
        logic [7:0] prog [9];
        prog = '{8'h90, 8'h0A, 8'h94, 8'h0B, 8'h18, 8'h19, 8'hD8, 8'h0D, 8'hFF};
        for (int i = 0; i < 256; i++) mem[i] = 8'hFF;
        for (int i = 0; i < 9; i++) mem[i] = prog[i];
    endtask

    task automatic pulse_run();
        run = 1'b1;
        tick();
        run = 1'b0;
    endtask

    task automatic wait_halt(input string name, input int bound);
        for (int i = 0; i < bound && !halted; i++) tick();
        check(name, halted, 1);
    endtask

    task automatic wait_valid(input string name, input int bound);
        for (int i = 0; i < bound && !issue_valid; i++) tick();
        check(name, issue_valid, 1);
    endtask

    task automatic monitor();
        iss_t got;
        iss_t held;
        iss_t e;
        bit   stall;
        stall = 0;
        held = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall = 0;
            end else if (issue_valid) begin
                got = {issue_opcode, issue_rd, issue_rs, issue_imm};
                if (stall) check("stall_hold", got, held);
                if (issue_ready) begin
                    n_issued++;
                    stall = 0;
                    if (exp_q.size() == 0) begin
                        check("extra_issue", got, 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        check("issue", got, e);
                    end
                end else begin
                    held = got;
                    stall = 1;
                end
            end else begin
                stall = 0;
            end
        end
    endtask

    initial begin
        logic [7:0] hpc;
        int         h;
        int         base;
        rst = 1'b1;
        run = 1'b0;
        issue_ready = 1'b1;
        redir_valid = 1'b0;
        redir_addr = 8'h00;
`ifdef FETCH_SINGLE_STEP_EN
        step = 1'b1;
`endif
        for (int i = 0; i < 256; i++) mem[i] = 8'hFF;
        fork
            monitor();
        join_none

        // Reset state
        do_reset();
        check("rst_pc", pc, 8'h00);
        check("rst_valid", issue_valid, 0);
        check("rst_halted", halted, 0);
        check("rst_fields", {issue_opcode, issue_rd, issue_rs, issue_imm}, 16'h0000);
        repeat (3) tick();
        check("idle_no_run_pc", pc, 8'h00);

        // Straight-line program, always ready
        load_prog1();
        model_walk(8'h00, 1000, hpc);
        pulse_run();
        wait_halt("t1_halt", 200);
        repeat (4) tick();
        check("t1_drained", exp_q.size(), 0);
        check("t1_halt_pc", pc, hpc);

        // First issue stalled for 4 cycles
        do_reset();
        load_prog1();
        model_walk(8'h00, 1000, hpc);
        ready_force = 1'b0;
        pulse_run();
        wait_valid("t2_first_valid", 20);
        for (int i = 0; i < 4; i++) begin
            check("t2_valid_held", issue_valid, 1);
            check("t2_pc_held", pc, 8'h02);
            if (i == 3) ready_force = 1'b1;
            tick();
        end
        wait_halt("t2_halt", 200);
        repeat (4) tick();
        check("t2_drained", exp_q.size(), 0);
        check("t2_halt_pc", pc, hpc);

        // Redirect to 0xFF; 2-byte instruction wraps its immediate fetch to 0x00
        do_reset();
        for (int i = 0; i < 256; i++) mem[i] = 8'hFF;
        mem[8'hFF] = 8'h90;
        mem[8'h00] = 8'h33;
        mem[8'h01] = 8'h00;
        model_walk(8'hFF, 1000, hpc);
        pulse_run();
        redir_valid = 1'b1;
        redir_addr = 8'hFF;
        tick();
        redir_valid = 1'b0;
        wait_valid("t3_valid", 20);
        check("t3_pc_after_wrap", pc, 8'h01);
        wait_halt("t3_halt", 200);
        repeat (3) tick();
        check("t3_drained", exp_q.size(), 0);
        check("t3_halt_pc", pc, hpc);

        // Redirect during FETCH_IMM of the first LOAD
        do_reset();
        load_prog1();
        model_walk(8'h06, 1000, hpc);
        pulse_run();
        tick();
        redir_valid = 1'b1;
        redir_addr = 8'h06;
        tick();
        redir_valid = 1'b0;
        wait_halt("t4_halt", 200);
        repeat (3) tick();
        check("t4_drained", exp_q.size(), 0);
        check("t4_halt_pc", pc, hpc);

        // Asynchronous reset while an issue is pending
        do_reset();
        load_prog1();
        ready_force = 1'b0;
        pulse_run();
        wait_valid("t5_valid", 20);
        rst = 1'b1;
        #1;
        check("t5_async_valid", issue_valid, 0);
        check("t5_async_pc", pc, 8'h00);
        check("t5_async_halted", halted, 0);
        tick();
        rst = 1'b0;
        ready_force = 1'b1;
        repeat (5) tick();
        check("t5_idle_valid", issue_valid, 0);
        check("t5_idle_pc", pc, 8'h00);

        // Randomized programs with random backpressure
        for (int r = 0; r < 8; r++) begin
            do_reset();
            for (int i = 0; i < 256; i++) mem[i] = 8'($urandom_range(0, 254));
            h = $urandom_range(2, 60);
            mem[h - 1] = 8'h00;
            mem[h] = 8'hFF;
            model_walk(8'h00, 1000, hpc);
            rand_mode = 1;
            pulse_run();
            wait_halt("rnd_halt", 3000);
            repeat (4) tick();
            rand_mode = 0;
            check("rnd_drained", exp_q.size(), 0);
            check("rnd_halt_pc", pc, hpc);
        end

`ifdef FETCH_SINGLE_STEP_EN
        // Single-step: exactly one instruction per step pulse
        do_reset();
        load_prog1();
        step = 1'b0;
        model_walk(8'h00, 3, hpc);
        base = n_issued;
        pulse_run();
        repeat (5) tick();
        check("step_none_before", n_issued - base, 0);
        for (int k = 0; k < 3; k++) begin
            step = 1'b1;
            tick();
            step = 1'b0;
            repeat (9) tick();
            check("step_count", n_issued - base, k + 1);
        end
        repeat (10) tick();
        check("step_total", n_issued - base, 3);
        check("step_drained", exp_q.size(), 0);
        check("step_not_halted", halted, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
